// File: rtl/mult_unit.sv
// Sequential radix-2 shift-add multiplier for MULT/MULTU.
// The core always multiplies unsigned magnitudes. Signed results are
// recovered by negating the 2W-bit product. The accumulate adder is a
// ripple chain of 4-bit carry-lookahead slices.

module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // generate/propagate terms with full lookahead carries inside the slice
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SLICES = WIDTH / 4;
  localparam int CW     = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mag_a;
  logic               neg;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   add_sum;
  logic [SLICES:0]    carry;
  logic [WIDTH:0]     upper_next;
  logic [2*WIDTH:0]   acc_shifted;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fixed;
  logic               last_step;

  // Accumulate adder: acc upper half plus the multiplicand magnitude,
  // one CLA slice per nibble, slice carry-out feeding the next slice.
  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < SLICES; gi++) begin : g_cla
      cla4 u_cla (
        .x    (acc[WIDTH + 4*gi +: 4]),
        .y    (mag_a[4*gi +: 4]),
        .cin  (carry[gi]),
        .sum  (add_sum[4*gi +: 4]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Operand magnitudes, one shift-add step, and the sign-corrected product.
  // The top accumulator bit is always zero before an add because every
  // step shifts a zero into it, so the slice carry-out becomes the new top.
  always_comb begin
    a_mag       = (is_signed & a[WIDTH-1]) ? -a : a;
    b_mag       = (is_signed & b[WIDTH-1]) ? -b : b;
    upper_next  = acc[0] ? {carry[SLICES], add_sum} : acc[2*WIDTH:WIDTH];
    acc_shifted = {1'b0, upper_next, acc[WIDTH-1:1]};
    prod        = acc[2*WIDTH-1:0];
    prod_fixed  = neg ? -prod : prod;
    last_step   = (count == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one RUN cycle per multiplier bit, then a sign fix-up
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_step) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift-add while running, publish on fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= a_mag;
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= {{(WIDTH+1){1'b0}}, b_mag};
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_shifted;
          count <= count + CW'(1);
        end
        FIX: begin
          hi   <= prod_fixed[2*WIDTH-1:WIDTH];
          lo   <= prod_fixed[WIDTH-1:0];
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Sequential 32x32 multiplier for the MIPS MULT/MULTU path. Produces the 64-bit product into HI/LO.
- Sits directly downstream of the 4-bit carry-lookahead adder cell. Its per-iteration accumulate adder is a chain of WIDTH/4 such 4-bit CLA slices, with slice cout driving the next slice's cin.
- Radix-2 shift-add, one partial product per clock. The core is only ever computing in its unsigned form; the signed variant uses sign-magnitude correction.

Parameters:
- WIDTH, 32, operand width. Must be a multiple of 4 (one CLA slice per 4 bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled on a rising edge when no operation is in progress.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU. Sampled with start.
- a  input  WIDTH  multiplicand (rs). Sampled with start.
- b  input  WIDTH  multiplier (rt). Sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when hi/lo have just been updated.
- hi  output  WIDTH  upper half of the product.
- lo  output  WIDTH  lower half of the product.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0. Releasing reset does not start an operation.
- States: IDLE, RUN, FIX. The DONE condition is IDLE with done=1.
- IDLE, start=1 at edge E0:
  - Latch mag_a = (is_signed & a[WIDTH-1]) ? -a : a, and mag_b likewise.
  - Latch neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Set acc = {(WIDTH+1)'b0, mag_b}, counter=0, state=RUN, busy=1.
- Magnitude of the most negative value (0x80000000) is 0x80000000, treated as unsigned. This is correct, not overflow.
- RUN, each edge:
  - If acc[0]=1, upper = acc[2W:W] + mag_a (W+1 bits, carry kept); else upper unchanged.
  - Then shift the whole acc right by 1, counter+1.
  - After 32 RUN edges (E1..E32, counter reaches WIDTH), state=FIX.
- FIX, edge E33:
  - hi/lo = neg ? -(acc[2W-1:0]) : acc[2W-1:0], as a 64-bit two's complement negate.
  - done=1, busy=0, state=IDLE.
- done is high for exactly the cycle after E33 and clears at E34 unless a new completion occurs.
- Latency: start at E0 gives results visible after E33, i.e. 33 clocks. Throughput is one operation per 33 clocks.
- busy is 1 in the cycles after E0 through E33, and 0 once done rises.
- start while busy=1 is ignored. It is not queued, and operands are not re-sampled.
- start in the same cycle done=1 is accepted: the new E0 coincides with done's falling edge.
- hi/lo hold their last value between completions and never show intermediate accumulator contents.
- Reset mid-operation aborts: no done pulse, and hi/lo are cleared to 0.
- a and b may change freely after E0 without affecting the result.

Test Plan:
- Unsigned basic: is_signed=0, a=3, b=5 -> done exactly 33 clocks after start; hi=0x00000000, lo=0x0000000F; busy high for 33 cycles.
- Unsigned max: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001 (exercises full carry chain every iteration).
- Signed mixed: is_signed=1, a=0xFFFFFFFF (-1), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9. Then signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Start-while-busy: start a=2,b=2; at cycle 10 pulse start with a=9,b=9 -> result hi=0, lo=4, single done pulse. Back-to-back start on the done cycle with a=6,b=7 -> second done 33 clocks later, lo=42.
- Reset mid-op: start a=100,b=100, assert rst_n=0 at cycle 15 for 2 cycles -> busy=0, done=0, hi=lo=0 immediately. No done pulse afterwards. A fresh start then gives lo=10000 normally.
